// File: rtl/blit_coordgen.sv
// Blitter pixel-coordinate sequencer: walks a rectangle in raster order or a line with
// integer Bresenham, presenting one registered pixel per unstalled cycle on the p2_* bus.
//
// state | meaning
// IDLE  | waiting for a command; run flags and p2_last low, coordinates hold
// RECT  | presenting rectangle pixels; returns to IDLE the cycle after the last one
// LINE  | presenting Bresenham line pixels; returns to IDLE the cycle after the last one

module blit_coordgen #(
    parameter int COORD_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_op,
    input  logic [COORD_W-1:0] cmd_dest_x,
    input  logic [COORD_W-1:0] cmd_dest_y,
    input  logic [COORD_W-1:0] cmd_src_x,
    input  logic [COORD_W-1:0] cmd_src_y,
    input  logic [COORD_W-1:0] cmd_width,
    input  logic [COORD_W-1:0] cmd_height,
    input  logic [COORD_W-1:0] cmd_x2,
    input  logic [COORD_W-1:0] cmd_y2,
    input  logic               stall,
    output logic               busy,
    output logic [COORD_W-1:0] p2_rect_dest_x,
    output logic [COORD_W-1:0] p2_rect_dest_y,
    output logic [COORD_W-1:0] p2_rect_src_x,
    output logic [COORD_W-1:0] p2_rect_src_y,
    output logic [COORD_W-1:0] p2_line_x,
    output logic [COORD_W-1:0] p2_line_y,
    output logic               p2_run_rect,
    output logic               p2_run_line,
    output logic               p2_last
);
    localparam int DW = COORD_W + 2;
    localparam int EW = COORD_W + 3;
    localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

    typedef enum logic [1:0] {IDLE = 2'd0, RECT = 2'd1, LINE = 2'd2} state_t;

    state_t state_q, state_d;
    logic [COORD_W-1:0] org_dx_q, org_dx_d, org_dy_q, org_dy_d;
    logic [COORD_W-1:0] org_sx_q, org_sx_d, org_sy_q, org_sy_d;
    logic [COORD_W-1:0] width_q, width_d, height_q, height_d;
    logic [COORD_W-1:0] xcnt_q, xcnt_d, ycnt_q, ycnt_d;
    logic [COORD_W-1:0] lx_q, lx_d, ly_q, ly_d, lx2_q, lx2_d, ly2_q, ly2_d;
    logic signed [DW-1:0] dx_q, dx_d, dy_q, dy_d;
    logic signed [EW-1:0] err_q, err_d;
    logic sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
    logic [COORD_W-1:0] rdx_q, rdx_d, rdy_q, rdy_d, rsx_q, rsx_d, rsy_q, rsy_d;
    logic [COORD_W-1:0] olx_q, olx_d, oly_q, oly_d;
    logic run_rect_q, run_rect_d, run_line_q, run_line_d, last_q, last_d;

    // Line setup: signed deltas one bit wider than the coordinates so wrap cannot alias.
    logic signed [COORD_W:0] diff_x, diff_y;
    logic [COORD_W:0] abs_x, abs_y;
    logic signed [DW-1:0] new_dx, new_dy;
    assign diff_x = $signed({cmd_x2[COORD_W-1], cmd_x2}) - $signed({cmd_dest_x[COORD_W-1], cmd_dest_x});
    assign diff_y = $signed({cmd_y2[COORD_W-1], cmd_y2}) - $signed({cmd_dest_y[COORD_W-1], cmd_dest_y});
    assign abs_x  = diff_x[COORD_W] ? $unsigned(-diff_x) : $unsigned(diff_x);
    assign abs_y  = diff_y[COORD_W] ? $unsigned(-diff_y) : $unsigned(diff_y);
    assign new_dx = $signed({1'b0, abs_x});
    assign new_dy = -$signed({1'b0, abs_y});

    logic signed [EW:0] e2, dx_e, dy_e;
    logic step_x, step_y, rect_end_x, rect_end_y, line_at_end;
    assign e2          = {err_q, 1'b0};
    assign dx_e        = {{2{dx_q[DW-1]}}, dx_q};
    assign dy_e        = {{2{dy_q[DW-1]}}, dy_q};
    assign step_x      = (e2 >= dy_e);
    assign step_y      = (e2 <= dx_e);
    assign rect_end_x  = (xcnt_q == width_q - ONE);
    assign rect_end_y  = (ycnt_q == height_q - ONE);
    assign line_at_end = (lx_q == lx2_q) && (ly_q == ly2_q);

    assign cmd_ready = (state_q == IDLE) && !stall;
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        org_dx_d   = org_dx_q;
        org_dy_d   = org_dy_q;
        org_sx_d   = org_sx_q;
        org_sy_d   = org_sy_q;
        width_d    = width_q;
        height_d   = height_q;
        xcnt_d     = xcnt_q;
        ycnt_d     = ycnt_q;
        lx_d       = lx_q;
        ly_d       = ly_q;
        lx2_d      = lx2_q;
        ly2_d      = ly2_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        err_d      = err_q;
        sx_neg_d   = sx_neg_q;
        sy_neg_d   = sy_neg_q;
        rdx_d      = rdx_q;
        rdy_d      = rdy_q;
        rsx_d      = rsx_q;
        rsy_d      = rsy_q;
        olx_d      = olx_q;
        oly_d      = oly_q;
        run_rect_d = 1'b0;
        run_line_d = 1'b0;
        last_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (!cmd_op) begin
                        if (cmd_width != '0 && cmd_height != '0) begin
                            org_dx_d = cmd_dest_x;
                            org_dy_d = cmd_dest_y;
                            org_sx_d = cmd_src_x;
                            org_sy_d = cmd_src_y;
                            width_d  = cmd_width;
                            height_d = cmd_height;
                            xcnt_d   = '0;
                            ycnt_d   = '0;
                            state_d  = RECT;
                        end
                    end else begin
                        lx_d     = cmd_dest_x;
                        ly_d     = cmd_dest_y;
                        lx2_d    = cmd_x2;
                        ly2_d    = cmd_y2;
                        dx_d     = new_dx;
                        dy_d     = new_dy;
                        sx_neg_d = diff_x[COORD_W];
                        sy_neg_d = diff_y[COORD_W];
                        err_d    = {new_dx[DW-1], new_dx} + {new_dy[DW-1], new_dy};
                        state_d  = LINE;
                    end
                end
            end
            RECT: begin
                // The last pixel stays on the bus for one cycle before dropping to IDLE.
                if (last_q) begin
                    state_d = IDLE;
                end else begin
                    run_rect_d = 1'b1;
                    rdx_d      = org_dx_q + xcnt_q;
                    rdy_d      = org_dy_q + ycnt_q;
                    rsx_d      = org_sx_q + xcnt_q;
                    rsy_d      = org_sy_q + ycnt_q;
                    last_d     = rect_end_x && rect_end_y;
                    if (rect_end_x) begin
                        xcnt_d = '0;
                        ycnt_d = ycnt_q + ONE;
                    end else begin
                        xcnt_d = xcnt_q + ONE;
                    end
                end
            end
            LINE: begin
                if (last_q) begin
                    state_d = IDLE;
                end else begin
                    run_line_d = 1'b1;
                    olx_d      = lx_q;
                    oly_d      = ly_q;
                    last_d     = line_at_end;
                    if (!line_at_end) begin
                        if (step_x) begin
                            err_d = err_d + {dy_q[DW-1], dy_q};
                            lx_d  = sx_neg_q ? lx_q - ONE : lx_q + ONE;
                        end
                        if (step_y) begin
                            err_d = err_d + {dx_q[DW-1], dx_q};
                            ly_d  = sy_neg_q ? ly_q - ONE : ly_q + ONE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            org_dx_q   <= '0;
            org_dy_q   <= '0;
            org_sx_q   <= '0;
            org_sy_q   <= '0;
            width_q    <= '0;
            height_q   <= '0;
            xcnt_q     <= '0;
            ycnt_q     <= '0;
            lx_q       <= '0;
            ly_q       <= '0;
            lx2_q      <= '0;
            ly2_q      <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            err_q      <= '0;
            sx_neg_q   <= 1'b0;
            sy_neg_q   <= 1'b0;
            rdx_q      <= '0;
            rdy_q      <= '0;
            rsx_q      <= '0;
            rsy_q      <= '0;
            olx_q      <= '0;
            oly_q      <= '0;
            run_rect_q <= 1'b0;
            run_line_q <= 1'b0;
            last_q     <= 1'b0;
        end else if (!stall) begin
            state_q    <= state_d;
            org_dx_q   <= org_dx_d;
            org_dy_q   <= org_dy_d;
            org_sx_q   <= org_sx_d;
            org_sy_q   <= org_sy_d;
            width_q    <= width_d;
            height_q   <= height_d;
            xcnt_q     <= xcnt_d;
            ycnt_q     <= ycnt_d;
            lx_q       <= lx_d;
            ly_q       <= ly_d;
            lx2_q      <= lx2_d;
            ly2_q      <= ly2_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            err_q      <= err_d;
            sx_neg_q   <= sx_neg_d;
            sy_neg_q   <= sy_neg_d;
            rdx_q      <= rdx_d;
            rdy_q      <= rdy_d;
            rsx_q      <= rsx_d;
            rsy_q      <= rsy_d;
            olx_q      <= olx_d;
            oly_q      <= oly_d;
            run_rect_q <= run_rect_d;
            run_line_q <= run_line_d;
            last_q     <= last_d;
        end
    end

    assign p2_rect_dest_x = rdx_q;
    assign p2_rect_dest_y = rdy_q;
    assign p2_rect_src_x  = rsx_q;
    assign p2_rect_src_y  = rsy_q;
    assign p2_line_x      = olx_q;
    assign p2_line_y      = oly_q;
    assign p2_run_rect    = run_rect_q;
    assign p2_run_line    = run_line_q;
    assign p2_last        = last_q;

endmodule

// File: tb/tb_blit_coordgen.sv
// Bench for blit_coordgen: directed and randomized commands checked against a queue of
// expected pixels built from plain rectangle loops and integer Bresenham.

`define CHK(tag, obs, exp) \
    begin \
        checks++; \
        assert ((obs) === (exp)) else begin \
            errors++; \
            $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); \
        end \
    end

module tb_blit_coordgen;
    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_op, stall, busy;
    logic [15:0] cmd_dest_x, cmd_dest_y, cmd_src_x, cmd_src_y;
    logic [15:0] cmd_width, cmd_height, cmd_x2, cmd_y2;
    logic [15:0] p2_rect_dest_x, p2_rect_dest_y, p2_rect_src_x, p2_rect_src_y;
    logic [15:0] p2_line_x, p2_line_y;
    logic        p2_run_rect, p2_run_line, p2_last;
    logic [98:0] outs;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        logic [15:0] d;
    } pix_t;
    pix_t exp_q[$];

    logic [15:0] mdl_rdx, mdl_rdy, mdl_rsx, mdl_rsy, mdl_lx, mdl_ly;

    blit_coordgen #(.COORD_W(16)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dest_x(cmd_dest_x), .cmd_dest_y(cmd_dest_y),
        .cmd_src_x(cmd_src_x), .cmd_src_y(cmd_src_y),
        .cmd_width(cmd_width), .cmd_height(cmd_height),
        .cmd_x2(cmd_x2), .cmd_y2(cmd_y2),
        .stall(stall), .busy(busy),
        .p2_rect_dest_x(p2_rect_dest_x), .p2_rect_dest_y(p2_rect_dest_y),
        .p2_rect_src_x(p2_rect_src_x), .p2_rect_src_y(p2_rect_src_y),
        .p2_line_x(p2_line_x), .p2_line_y(p2_line_y),
        .p2_run_rect(p2_run_rect), .p2_run_line(p2_run_line), .p2_last(p2_last)
    );

    always #5 clock = ~clock;

    assign outs = {p2_rect_dest_x, p2_rect_dest_y, p2_rect_src_x, p2_rect_src_y,
                   p2_line_x, p2_line_y, p2_run_rect, p2_run_line, p2_last};

    function automatic void model_rect(input logic [15:0] ax, ay, bx, by, w, h);
        pix_t p;
        for (int j = 0; j < int'(h); j++) begin
            for (int i = 0; i < int'(w); i++) begin
                p.a = ax + 16'(i);
                p.b = ay + 16'(j);
                p.c = bx + 16'(i);
                p.d = by + 16'(j);
                exp_q.push_back(p);
            end
        end
    endfunction

    function automatic void model_line(input logic [15:0] x0, y0, x1, y1);
        int x, y, xe, ye, dx, dy, sx, sy, err, e2;
        pix_t p;
        x  = int'($signed(x0));
        y  = int'($signed(y0));
        xe = int'($signed(x1));
        ye = int'($signed(y1));
        dx = (xe > x) ? xe - x : x - xe;
        dy = (ye > y) ? y - ye : ye - y;
        sx = (xe < x) ? -1 : 1;
        sy = (ye < y) ? -1 : 1;
        err = dx + dy;
        for (int n = 0; n < 70000; n++) begin
            p = '0;
            p.a = 16'(x);
            p.b = 16'(y);
            exp_q.push_back(p);
            if (x == xe && y == ye) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endfunction

    task automatic check_holds();
        `CHK("hold_rect_dest_x", p2_rect_dest_x, mdl_rdx)
        `CHK("hold_rect_dest_y", p2_rect_dest_y, mdl_rdy)
        `CHK("hold_rect_src_x", p2_rect_src_x, mdl_rsx)
        `CHK("hold_rect_src_y", p2_rect_src_y, mdl_rsy)
        `CHK("hold_line_x", p2_line_x, mdl_lx)
        `CHK("hold_line_y", p2_line_y, mdl_ly)
    endtask

    // Starts and ends one sample step (#1) after a rising edge. smode: 0 none, 1 random, 2 three-cycle stall after pixel 2.
    task automatic do_cmd(input logic op, input logic [15:0] ax, ay, bx, by, w, h, x2, y2, input int smode);
        pix_t e;
        logic [98:0] snap;
        logic stalled_prev, done, stalled_once;
        int budget, npix, stall_left;
        exp_q.delete();
        if (!op) model_rect(ax, ay, bx, by, w, h);
        else     model_line(ax, ay, x2, y2);
        stall = 1'b0;
        cmd_op = op; cmd_dest_x = ax; cmd_dest_y = ay; cmd_src_x = bx; cmd_src_y = by;
        cmd_width = w; cmd_height = h; cmd_x2 = x2; cmd_y2 = y2;
        cmd_valid = 1'b1;
        #0;
        `CHK("cmd_ready_idle", cmd_ready, 1'b1)
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        cmd_op = 1'($urandom); cmd_dest_x = 16'($urandom); cmd_dest_y = 16'($urandom);
        cmd_src_x = 16'($urandom); cmd_src_y = 16'($urandom); cmd_width = 16'($urandom);
        cmd_height = 16'($urandom); cmd_x2 = 16'($urandom); cmd_y2 = 16'($urandom);
        if (exp_q.size() == 0) begin
            `CHK("empty_busy", busy, 1'b0)
            `CHK("empty_run", {p2_run_rect, p2_run_line}, 2'b00)
            check_holds();
            return;
        end
        `CHK("busy_after_accept", busy, 1'b1)
        `CHK("no_pixel_on_accept", {p2_run_rect, p2_run_line}, 2'b00)
        done = 1'b0; stalled_once = 1'b0; npix = 0; stall_left = 0;
        budget = exp_q.size() * 6 + 40;
        while (!done && budget > 0) begin
            budget--;
            snap = outs;
            if (smode == 1) stall = ($urandom_range(0, 3) == 0);
            else if (smode == 2 && npix == 2 && !stalled_once) begin
                stall = 1'b1; stall_left = 3; stalled_once = 1'b1;
            end
            stalled_prev = stall;
            @(posedge clock); #1;
            if (stalled_prev) begin
                `CHK("stall_hold", outs, snap)
                `CHK("stall_busy", busy, 1'b1)
                `CHK("stall_ready", cmd_ready, 1'b0)
                if (smode == 2) begin
                    stall_left--;
                    if (stall_left == 0) stall = 1'b0;
                end
            end else if (exp_q.size() == 0) begin
                `CHK("end_busy", busy, 1'b0)
                `CHK("end_run", {p2_run_rect, p2_run_line, p2_last}, 3'b000)
                `CHK("end_ready", cmd_ready, 1'b1)
                done = 1'b1;
            end else begin
                e = exp_q.pop_front();
                npix++;
                if (!op) begin
                    `CHK("rect_run", {p2_run_rect, p2_run_line}, 2'b10)
                    `CHK("rect_dest_x", p2_rect_dest_x, e.a)
                    `CHK("rect_dest_y", p2_rect_dest_y, e.b)
                    `CHK("rect_src_x", p2_rect_src_x, e.c)
                    `CHK("rect_src_y", p2_rect_src_y, e.d)
                    mdl_rdx = e.a; mdl_rdy = e.b; mdl_rsx = e.c; mdl_rsy = e.d;
                end else begin
                    `CHK("line_run", {p2_run_rect, p2_run_line}, 2'b01)
                    `CHK("line_x", p2_line_x, e.a)
                    `CHK("line_y", p2_line_y, e.b)
                    mdl_lx = e.a; mdl_ly = e.b;
                end
                `CHK("pixel_last", p2_last, (exp_q.size() == 0))
                `CHK("pixel_busy", busy, 1'b1)
            end
        end
        stall = 1'b0;
        `CHK("cmd_completed", done, 1'b1)
        check_holds();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int xi, yi, x1i, y1i;
        reset = 1'b0; stall = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0;
        cmd_dest_x = '0; cmd_dest_y = '0; cmd_src_x = '0; cmd_src_y = '0;
        cmd_width = '0; cmd_height = '0; cmd_x2 = '0; cmd_y2 = '0;
        mdl_rdx = '0; mdl_rdy = '0; mdl_rsx = '0; mdl_rsy = '0; mdl_lx = '0; mdl_ly = '0;
        #1 reset = 1'b1;
        #2;
        `CHK("reset_outputs", outs, 99'd0)
        `CHK("reset_busy", busy, 1'b0)
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        `CHK("post_reset_ready", cmd_ready, 1'b1)

        do_cmd(1'b0, 16'd10, 16'd20, 16'd0, 16'd5, 16'd3, 16'd2, 16'd0, 16'd0, 0);
        do_cmd(1'b1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd4, 16'd2, 0);
        do_cmd(1'b1, 16'd5, 16'd5, 16'd0, 16'd0, 16'd0, 16'd0, 16'd5, 16'd2, 0);
        do_cmd(1'b1, 16'd7, 16'd7, 16'd0, 16'd0, 16'd0, 16'd0, 16'd7, 16'd7, 0);
        do_cmd(1'b0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd4, 16'd0, 16'd0, 0);
        do_cmd(1'b0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd4, 16'd0, 16'd0, 16'd0, 0);
        do_cmd(1'b0, 16'hfffe, 16'hffff, 16'd100, 16'd200, 16'd3, 16'd2, 16'd0, 16'd0, 0);
        do_cmd(1'b0, 16'd30, 16'd40, 16'd50, 16'd60, 16'd2, 16'd2, 16'd0, 16'd0, 2);

        // Stalled IDLE must refuse a command even with cmd_valid high.
        stall = 1'b1;
        cmd_op = 1'b0; cmd_width = 16'd2; cmd_height = 16'd2; cmd_valid = 1'b1;
        #0;
        `CHK("idle_stall_ready", cmd_ready, 1'b0)
        @(posedge clock); #1;
        `CHK("idle_stall_busy", busy, 1'b0)
        `CHK("idle_stall_run", {p2_run_rect, p2_run_line}, 2'b00)
        cmd_valid = 1'b0; stall = 1'b0;

        // Asynchronous reset while the third line pixel is on the bus.
        exp_q.delete();
        model_line(16'd0, 16'd0, 16'd9, 16'd3);
        cmd_op = 1'b1; cmd_dest_x = 16'd0; cmd_dest_y = 16'd0; cmd_x2 = 16'd9; cmd_y2 = 16'd3;
        cmd_valid = 1'b1;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        `CHK("midline_run", p2_run_line, 1'b1)
        `CHK("midline_x", p2_line_x, exp_q[2].a)
        `CHK("midline_y", p2_line_y, exp_q[2].b)
        #2 reset = 1'b1;
        #1;
        `CHK("async_reset_outputs", outs, 99'd0)
        `CHK("async_reset_busy", busy, 1'b0)
        #2 reset = 1'b0;
        mdl_rdx = '0; mdl_rdy = '0; mdl_rsx = '0; mdl_rsy = '0; mdl_lx = '0; mdl_ly = '0;
        repeat (2) begin
            @(posedge clock); #1;
            `CHK("after_reset_idle", {busy, p2_run_rect, p2_run_line, p2_last}, 4'b0000)
        end
        do_cmd(1'b0, 16'd7, 16'd8, 16'd9, 16'd10, 16'd4, 16'd3, 16'd0, 16'd0, 0);

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 1) == 0) begin
                do_cmd(1'b0, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                       16'($urandom_range(0, 5)), 16'($urandom_range(0, 4)), 16'd0, 16'd0,
                       int'($urandom_range(0, 1)));
            end else begin
                xi  = int'($urandom_range(0, 400)) - 200;
                yi  = int'($urandom_range(0, 400)) - 200;
                x1i = xi + int'($urandom_range(0, 60)) - 30;
                y1i = yi + int'($urandom_range(0, 60)) - 30;
                do_cmd(1'b1, 16'(xi), 16'(yi), 16'd0, 16'd0, 16'd0, 16'd0, 16'(x1i), 16'(y1i),
                       int'($urandom_range(0, 1)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/blit_coordgen.md
Name: blit_coordgen

Overview:
Pixel-coordinate sequencer for the blitter, directly upstream of the address-generation stage. Accepts one rectangle-copy or line-draw command at a time and emits one pixel coordinate per unstalled cycle on the p2_* bus. Rectangles are walked in raster order and lines use integer Bresenham. Clipping, address arithmetic and text-mode bit selection stay downstream.

Parameters:
COORD_W, 16, width of all coordinate/size fields (two's-complement wrap for coordinates)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_op  in  1  0 = rectangle, 1 = line
cmd_dest_x  in  16  rect dest origin x / line start x
cmd_dest_y  in  16  rect dest origin y / line start y
cmd_src_x  in  16  rect source origin x (ignored for line)
cmd_src_y  in  16  rect source origin y (ignored for line)
cmd_width  in  16  rect width in pixels (unsigned)
cmd_height  in  16  rect height in pixels (unsigned)
cmd_x2  in  16  line end x (inclusive)
cmd_y2  in  16  line end y (inclusive)
stall  in  1  downstream stall; freezes this block
busy  out  1  command in progress
p2_rect_dest_x  out  16  rect pixel dest x
p2_rect_dest_y  out  16  rect pixel dest y
p2_rect_src_x  out  16  rect pixel source x
p2_rect_src_y  out  16  rect pixel source y
p2_line_x  out  16  line pixel x
p2_line_y  out  16  line pixel y
p2_run_rect  out  1  rect pixel valid this cycle
p2_run_line  out  1  line pixel valid this cycle
p2_last  out  1  current pixel is the last of the command

Behaviour:
- Reset (async): state IDLE. All p2_* outputs 0. busy=0. Internal counters and error term 0.
- Global freeze: when stall=1, no register changes (state, counters, outputs). Outputs hold their values.
- cmd_ready = (state==IDLE) && !stall. busy = (state!=IDLE).
- States: IDLE, RECT, LINE.
- IDLE, command accepted, op=0:
  - width==0 or height==0: stay IDLE, no pixel emitted.
  - Otherwise latch origins/sizes, clear xcnt=ycnt=0, go RECT.
- RECT: each unstalled cycle presents one pixel with p2_run_rect=1:
  - dest = (dest_x+xcnt, dest_y+ycnt); src = (src_x+xcnt, src_y+ycnt). Sums are mod 2^16.
  - Advance: xcnt++. At xcnt==width-1, xcnt=0 and ycnt++.
  - After pixel (width-1, height-1): p2_last=1 on that pixel; next cycle go IDLE with run_rect=0.
- IDLE, command accepted, op=1: latch x=dest_x, y=dest_y, x2, y2. Compute:
  - dx = |x2-x|, dy = -|y2-y| (18-bit signed)
  - sx, sy = ±1
  - err = dx+dy
  - Go LINE. A line is never empty: start==end gives exactly one pixel.
- LINE: each unstalled cycle presents (x,y) with p2_run_line=1.
  - If x==x2 && y==y2: p2_last=1, next state IDLE.
  - Else e2 = 2*err. If e2>=dy: err+=dy, x+=sx. If e2<=dx: err+=dx, y+=sy. Both updates may occur in one cycle.
- Latency: command accepted at edge N; first pixel visible after edge N+1. Pixels are back-to-back with no bubbles absent stall. A w×h rect takes exactly w*h valid cycles. busy drops the cycle after p2_last is presented.
- In IDLE, run flags=0 and p2_last=0. Coordinate outputs hold their last values.
- cmd_* sampled only on acceptance; changes while busy are ignored.
- Reset mid-command aborts immediately; no further pixels emitted.
- Unused coordinate group (line outputs during rect and vice versa) holds its previous value.

Test Plan:
- Rect w=3 h=2 dest(10,20) src(0,5), no stall -> 6 cycles of run_rect with dest (10,20),(11,20),(12,20),(10,21),(11,21),(12,21). src_y 5,5,5,6,6,6. p2_last only on 6th. busy falls next cycle. cmd_ready returns.
- Line (0,0)->(4,2) -> exactly (0,0),(1,1),(2,1),(3,2),(4,2) with run_line=1. p2_last on (4,2).
- Vertical reverse line (5,5)->(5,2) -> (5,5),(5,4),(5,3),(5,2). Single-point line (7,7)->(7,7) -> one pixel with p2_last=1.
- Rect w=0 h=4 and w=4 h=0 -> no run_rect pulse, busy never asserted, next command accepted the following cycle.
- Rect 2×2 with stall high for 3 cycles after 2nd pixel -> 2nd pixel held stable all 3 cycles. Sequence resumes unchanged; still 4 distinct pixels. cmd_ready=0 while stalled in IDLE.
- Reset asserted asynchronously mid-line (3rd pixel) -> outputs 0 immediately without clock edge. IDLE after release. Next rect command runs correctly.
